// File: rtl/shiftadd_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and sizing helper.
package shiftadd_mul_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  // Iteration counter must hold values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shiftadd_mul_addern.sv
// Ripple-carry adder: WIDTH-bit sum plus carry-out, built from per-bit full adders.
module addern #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shiftadd_mul.sv
// Sequential unsigned shift-and-add multiplier: one add-and-shift step per clock,
// valid/ready handshakes on operands and product.
module shiftadd_mul
  import shiftadd_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int                CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  m;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  sum;
  logic              cout;

  // The adder always sees the high partial-product word and the multiplicand;
  // whether its result is used depends on the current multiplier bit.
  addern #(.WIDTH(WIDTH)) u_add (
    .a    (hi),
    .b    (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Handshake flags come straight from the state register, so no input reaches them combinationally.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign product   = {hi, lo};

  // Next-state decode; clear overrides every other request.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (in_valid)         state_next = ST_RUN;
        ST_RUN:  if (cnt == CNT_LAST)  state_next = ST_DONE;
        ST_DONE: if (out_ready)        state_next = ST_IDLE;
        default:                       state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: load operands, then shift the {hi, lo} accumulator right once per
  // iteration, folding in the adder result (carry included) when lo[0] is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else if (clear) begin
      m   <= '0;
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            m   <= a;
            hi  <= '0;
            lo  <= b;
            cnt <= '0;
          end
        end
        ST_RUN: begin
          if (lo[0]) begin
            hi <= {cout, sum[WIDTH-1:1]};
            lo <= {sum[0], lo[WIDTH-1:1]};
          end else begin
            hi <= {1'b0, hi[WIDTH-1:1]};
            lo <= {hi[0], lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftadd_mul.sv
// Scoreboard bench for shiftadd_mul: WIDTH=8 and WIDTH=2 instances, directed vectors.
module tb_shiftadd_mul;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clear, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        clear2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0]  a2, b2;
  logic [3:0]  product2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q8[$];
  logic [3:0]  q2[$];

  shiftadd_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  shiftadd_mul #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2), .product(product2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands to the 8-bit instance; optionally queue the expected product.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y,
                        input bit expect_it, input logic [15:0] exp);
    int n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    if (expect_it) q8.push_back(exp);
    tick();
    in_valid = 1'b0;
    chk("in_ready_low_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done8(input string name, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk(name, 32'(lat), 32'(exp_lat));
  endtask

  // Full transaction with out_ready high: accept, 8-edge latency, back to IDLE.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
    issue8(x, y, 1'b1, exp);
    wait_done8("latency8", 8);
    tick();
    chk("idle_after_done8", 32'(in_ready), 32'd1);
  endtask

  task automatic run2(input logic [1:0] x, input logic [1:0] y, input logic [3:0] exp);
    int lat = 0;
    a2 = x;
    b2 = y;
    in_valid2 = 1'b1;
    q2.push_back(exp);
    tick();
    in_valid2 = 1'b0;
    chk("in_ready2_low_after_accept", 32'(in_ready2), 32'd0);
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency2", 32'(lat), 32'd2);
    tick();
    chk("idle_after_done2", 32'(in_ready2), 32'd1);
  endtask

  // Monitor: every accepted product is popped and compared against the scoreboard.
  initial begin : monitor
    logic [15:0] e8;
    logic [3:0]  e2;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (out_valid && out_ready) begin
          if (q8.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_product8: got %0h expected none", product);
          end else begin
            e8 = q8.pop_front();
            chk("product8", 32'(product), 32'(e8));
          end
        end
        if (out_valid2 && out_ready2) begin
          if (q2.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_product2: got %0h expected none", product2);
          end else begin
            e2 = q2.pop_front();
            chk("product2", 32'(product2), 32'(e2));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit seen;
    rst_n = 1'b0;
    clear = 1'b0;   in_valid = 1'b0;   out_ready = 1'b1;   a = '0;  b = '0;
    clear2 = 1'b0;  in_valid2 = 1'b0;  out_ready2 = 1'b1;  a2 = '0; b2 = '0;
    repeat (2) tick();
    chk("reset_product", 32'(product), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    run8(8'd13,  8'd11,  16'h008F);
    run8(8'd255, 8'd255, 16'hFE01);
    run8(8'd0,   8'd200, 16'h0000);
    run8(8'd200, 8'd0,   16'h0000);

    // Backpressure: product held, in_ready low, concurrent operands ignored.
    out_ready = 1'b0;
    issue8(8'd7, 8'd9, 1'b1, 16'h003F);
    wait_done8("latency8_bp", 8);
    for (int i = 0; i < 5; i++) begin
      a = 8'd1;
      b = 8'd1;
      in_valid = 1'b1;
      chk("bp_product_hold", 32'(product), 32'h003F);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      tick();
    end
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_idle_after_ready", 32'(in_ready), 32'd1);
    chk("bp_valid_dropped", 32'(out_valid), 32'd0);

    // Abort during the third iteration.
    issue8(8'd100, 8'd3, 1'b0, 16'h0000);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run8(8'd5, 8'd6, 16'd30);

    // Asynchronous reset mid-run takes effect without a clock edge.
    issue8(8'd13, 8'd11, 1'b0, 16'h0000);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_product", 32'(product), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run2(2'd3, 2'd3, 4'h9);
    run2(2'd2, 2'd3, 4'h6);
    run8(8'd16, 8'd16, 16'h0100);

    repeat (3) tick();
    chk("queue8_drained", 32'(q8.size()), 32'd0);
    chk("queue2_drained", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
